// File: rtl/isram_rd_responder_pkg.sv
// Shared constants for the instruction-SRAM read responder: response codes,
// default base address and FSM state encodings.
package isram_rd_responder_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    localparam logic [31:0] ISRAM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RESP  = 2'd2
    } isram_state_e;

endpackage

// File: rtl/isram_rd_responder_if.sv
// AR + R read channel between the IFU fetch port (master) and the responder (slave).
interface isram_rd_responder_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic [1:0]            rresp;
    logic                  rready;

    modport master (output araddr, arvalid, rready, input arready, rdata, rvalid, rresp);
    modport slave  (input araddr, arvalid, rready, output arready, rdata, rvalid, rresp);
endinterface

// File: rtl/isram_delay_gen.sv
// Response-latency down-counter. With ISRAM_RAND_DELAY_EN defined, a 4-bit LFSR
// picks a 0..3 delay per transaction and requests occasional arready gaps.
module isram_delay_gen #(
    parameter int FIXED_DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic zero,
    output logic done,
    output logic ar_gate
);
    logic [3:0] cnt;
    logic [3:0] dly;

`ifdef ISRAM_RAND_DELAY_EN
    logic [3:0] lfsr;

    // x^4+x^3+1 Fibonacci form; the pre-advance value sets this transaction's delay
    always_ff @(posedge clk) begin
        if (rst)        lfsr <= 4'b1001;
        else if (start) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end

    assign dly     = {2'b00, lfsr[1:0]};
    assign ar_gate = lfsr[3];
`else
    assign dly     = 4'(FIXED_DELAY);
    assign ar_gate = 1'b0;
`endif

    assign zero = (dly == 4'd0);
    assign done = (cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (start)         cnt <= dly;
        else if (cnt != 4'd0)   cnt <= cnt - 4'd1;
    end

endmodule

// File: rtl/isram_rd_responder.sv
// Instruction-SRAM read responder: one outstanding fetch, programmable latency,
// preloadable word array. Optional random latency via ISRAM_RAND_DELAY_EN.
module isram_rd_responder
    import isram_rd_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    IDX_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = DATA_WIDTH'(ISRAM_BASE_ADDR),
    parameter int                    FIXED_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    isram_rd_responder_if.slave   bus,
    input  logic                  init_we,
    input  logic [IDX_WIDTH-1:0]  init_idx,
    input  logic [DATA_WIDTH-1:0] init_data
);
    logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

    isram_state_e          state;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] off;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  start;
    logic                  dly_zero;
    logic                  dly_done;
    logic                  ar_gate;

    assign start = (state == IDLE) && bus.arvalid && arready_q;
    assign off   = addr - BASE_ADDR;

    isram_delay_gen #(.FIXED_DELAY(FIXED_DELAY)) u_delay_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .zero    (dly_zero),
        .done    (dly_done),
        .ar_gate (ar_gate)
    );

    // Preload port is independent of the FSM; contents survive reset
    always_ff @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RRESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= bus.araddr;
                        arready_q <= 1'b0;
                        state     <= dly_zero ? RESP : DELAY;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                DELAY: begin
                    if (dly_done) state <= RESP;
                end
                RESP: begin
                    // First RESP cycle samples the array; the beat then holds until taken
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                        if (off[DATA_WIDTH-1:IDX_WIDTH+2] != '0) begin
                            rresp_q <= RRESP_DECERR;
                            rdata_q <= '0;
                        end else if (addr[1:0] != 2'b00) begin
                            rresp_q <= RRESP_SLVERR;
                            rdata_q <= '0;
                        end else begin
                            rresp_q <= RRESP_OKAY;
                            rdata_q <= mem[off[IDX_WIDTH+1:2]];
                        end
                    end else if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= ~ar_gate;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_isram_rd_responder.sv
// Directed bench for isram_rd_responder: a FIXED_DELAY=2 instance for decode,
// stall, sampling and reset cases, and a FIXED_DELAY=0 instance for back-to-back.
module tb_isram_rd_responder;
    import isram_rd_responder_pkg::*;

    localparam int IDXW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_we;
    logic [IDXW-1:0] init_idx;
    logic [31:0]     init_data;

    int          checks   = 0;
    int          failures = 0;
    int          gaps     = 0;
    int          lat;
    logic [31:0] shadow [1024];

    isram_rd_responder_if #(.DATA_WIDTH(32)) bus2 ();
    isram_rd_responder_if #(.DATA_WIDTH(32)) bus0 ();

    isram_rd_responder #(.DATA_WIDTH(32), .IDX_WIDTH(IDXW), .BASE_ADDR(32'h8000_0000), .FIXED_DELAY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data)
    );

    isram_rd_responder #(.DATA_WIDTH(32), .IDX_WIDTH(IDXW), .BASE_ADDR(32'h8000_0000), .FIXED_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .init_we(init_we), .init_idx(init_idx), .init_data(init_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        init_we   = 1'b1;
        init_idx  = IDXW'(idx);
        init_data = d;
        step();
        init_we   = 1'b0;
        shadow[idx] = d;
    endtask

    // Waits (bounded) for arready, then handshakes; returns just after the AR edge
    task automatic ar_hs2(input logic [31:0] a);
        int n;
        n = 0;
        while (!bus2.arready && n < 20) begin
            step();
            n++;
        end
        if (n > 0) gaps++;
        chk("ar_ready", 64'(bus2.arready), 64'(1));
        bus2.araddr  = a;
        bus2.arvalid = 1'b1;
        step();
        bus2.arvalid = 1'b0;
    endtask

    task automatic wait_rv2(output int l);
        l = 0;
        while (!bus2.rvalid && l < 20) begin
            step();
            l++;
        end
    endtask

    task automatic fetch2(input string nm, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        int l;
        bus2.rready = 1'b1;
        ar_hs2(a);
        wait_rv2(l);
`ifdef ISRAM_RAND_DELAY_EN
        chk({nm, "_lat"}, 64'(l >= 1 && l <= 4), 64'(1));
`else
        chk({nm, "_lat"}, 64'(l), 64'(3));
`endif
        chk({nm, "_data"}, 64'(bus2.rdata), 64'(ed));
        chk({nm, "_resp"}, 64'(bus2.rresp), 64'(er));
        step();
        chk({nm, "_rvalid_drop"}, 64'(bus2.rvalid), 64'(0));
`ifndef ISRAM_RAND_DELAY_EN
        chk({nm, "_arready_back"}, 64'(bus2.arready), 64'(1));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_we = 1'b0; init_idx = '0; init_data = '0;
        bus2.arvalid = 1'b0; bus2.araddr = '0; bus2.rready = 1'b0;
        bus0.arvalid = 1'b0; bus0.araddr = '0; bus0.rready = 1'b0;
        step(); step();
        chk("rst_outputs2", 64'({bus2.arready, bus2.rvalid, bus2.rresp, bus2.rdata}), 64'(0));
        chk("rst_outputs0", 64'({bus0.arready, bus0.rvalid, bus0.rresp, bus0.rdata}), 64'(0));

        for (int i = 0; i < 16; i++) preload(i, 32'hC0DE_0000 | 32'(i));
        preload(3, 32'hDEAD_BEEF);
        preload(1023, 32'hCAFE_F00D);
        chk("arready_in_rst", 64'(bus2.arready), 64'(0));
        rst = 1'b0;
        step();
        chk("arready_after_rst2", 64'(bus2.arready), 64'(1));
        chk("arready_after_rst0", 64'(bus0.arready), 64'(1));

        vecs[0] = '{32'h8000_000C, 32'hDEAD_BEEF, RRESP_OKAY};
        vecs[1] = '{32'h8000_0000, 32'hC0DE_0000, RRESP_OKAY};
        vecs[2] = '{32'h8000_0004, 32'hC0DE_0001, RRESP_OKAY};
        vecs[3] = '{32'h8000_0FFC, 32'hCAFE_F00D, RRESP_OKAY};
        vecs[4] = '{32'h8000_1000, 32'h0000_0000, RRESP_DECERR};
        vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0000, RRESP_DECERR};
        vecs[6] = '{32'h8000_0006, 32'h0000_0000, RRESP_SLVERR};
        vecs[7] = '{32'h8000_1002, 32'h0000_0000, RRESP_DECERR};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, RRESP_DECERR};
        for (int i = 0; i < 9; i++)
            fetch2($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].resp);

`ifndef ISRAM_RAND_DELAY_EN
        // Stalled beat: data held, second address refused, preload doesn't touch latched rdata
        bus2.rready = 1'b0;
        ar_hs2(32'h8000_000C);
        wait_rv2(lat);
        bus2.araddr = 32'h8000_0000; bus2.arvalid = 1'b1;
        init_we = 1'b1; init_idx = 10'd3; init_data = 32'h0BAD_F00D;
        for (int k = 0; k < 5; k++) begin
            step();
            init_we = 1'b0;
            chk($sformatf("stall%0d", k), 64'({bus2.rvalid, bus2.arready, bus2.rresp, bus2.rdata}),
                64'({1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF}));
        end
        shadow[3] = 32'h0BAD_F00D;
        bus2.arvalid = 1'b0; bus2.rready = 1'b1;
        step();
        chk("stall_release", 64'({bus2.rvalid, bus2.arready}), 64'(2'b01));
        fetch2("rewrite_idx3", 32'h8000_000C, shadow[3], RRESP_OKAY);

        // Write during DELAY is visible
        bus2.rready = 1'b1;
        ar_hs2(32'h8000_0014);
        init_we = 1'b1; init_idx = 10'd5; init_data = 32'hA1A1_A1A1;
        step();
        init_we = 1'b0; shadow[5] = 32'hA1A1_A1A1;
        wait_rv2(lat);
        chk("delay_write_visible", 64'(bus2.rdata), 64'(32'hA1A1_A1A1));
        step();

        // Write on the RESP-entry edge is not visible
        ar_hs2(32'h8000_0018);
        step(); step();
        init_we = 1'b1; init_idx = 10'd6; init_data = 32'hB2B2_B2B2;
        step();
        init_we = 1'b0;
        chk("resp_entry_write_hidden", 64'({bus2.rvalid, bus2.rdata}), 64'({1'b1, 32'hC0DE_0006}));
        shadow[6] = 32'hB2B2_B2B2;
        step();
        fetch2("idx6_after", 32'h8000_0018, shadow[6], RRESP_OKAY);

        // Reset during DELAY, then during RESP
        ar_hs2(32'h8000_000C);
        step();
        rst = 1'b1; step();
        chk("rst_delay", 64'({bus2.rvalid, bus2.arready}), 64'(0));
        rst = 1'b0; step();
        chk("rst_delay_recover", 64'({bus2.rvalid, bus2.arready}), 64'(2'b01));
        bus2.rready = 1'b0;
        ar_hs2(32'h8000_000C);
        wait_rv2(lat);
        rst = 1'b1; step();
        chk("rst_resp", 64'({bus2.rvalid, bus2.arready}), 64'(0));
        rst = 1'b0; step();
        chk("rst_resp_recover", 64'({bus2.rvalid, bus2.arready}), 64'(2'b01));
        fetch2("reread_idx3", 32'h8000_000C, shadow[3], RRESP_OKAY);
        fetch2("reread_idx1023", 32'h8000_0FFC, shadow[1023], RRESP_OKAY);

        // Zero-delay instance, arvalid held high across two fetches
        bus0.araddr = 32'h8000_0000; bus0.arvalid = 1'b1; bus0.rready = 1'b1;
        chk("b2b_arready", 64'(bus0.arready), 64'(1));
        step();
        bus0.araddr = 32'h8000_0004;
        chk("b2b_hs0", 64'({bus0.rvalid, bus0.arready}), 64'(2'b00));
        step();
        chk("b2b_beat0", 64'({bus0.rvalid, bus0.rresp, bus0.rdata}), 64'({1'b1, 2'b00, shadow[0]}));
        step();
        chk("b2b_ret0", 64'({bus0.rvalid, bus0.arready}), 64'(2'b01));
        step();
        bus0.arvalid = 1'b0;
        chk("b2b_hs1", 64'({bus0.rvalid, bus0.arready}), 64'(2'b00));
        step();
        chk("b2b_beat1", 64'({bus0.rvalid, bus0.rresp, bus0.rdata}), 64'({1'b1, 2'b00, shadow[1]}));
        step();
        chk("b2b_done", 64'({bus0.rvalid, bus0.arready}), 64'(2'b01));
`endif

        gaps = 0;
        for (int i = 0; i < 20; i++)
            fetch2($sformatf("seq%0d", i), 32'h8000_0000 + 32'(4 * (i % 16)), shadow[i % 16], RRESP_OKAY);
`ifdef ISRAM_RAND_DELAY_EN
        chk("arready_gap_seen", 64'(gaps > 0), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
